// File: rtl/weight_loader_if.sv
// Kernel-load bus: upstream weight stream plus the shared flush/weight bus to the PE buffers.
interface weight_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PE     = 4
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [NUM_PE-1:0]     un_configed;
    logic [NUM_PE-1:0]     flush_kernel;
    logic [DATA_WIDTH-1:0] w_data;

    // Upstream handshake: a word moves on any cycle where s_valid && s_ready;
    // s_data must be held while s_valid is high and s_ready is low.
    modport master (
        input  s_data, s_valid, un_configed,
        output s_ready, flush_kernel, w_data
    );

    modport slave (
        output s_data, s_valid, un_configed,
        input  s_ready, flush_kernel, w_data
    );
endinterface

// File: rtl/weight_loader.sv
// Collects a kernel into a local FIFO, then strobes one PE and streams the kernel gaplessly.
// Optional feature: define WLOAD_REPLAY_EN to add the replay input (re-stream last kernel).
module weight_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int BUFFER_DEPTH = 16,
    parameter int NUM_PE       = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [7:0]                kernel_size,
    input  logic [$clog2(NUM_PE)-1:0] pe_sel,
`ifdef WLOAD_REPLAY_EN
    input  logic                      replay,
`endif
    weight_loader_if.master           bus,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                state_dbg
);
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        FLUSH  = 3'd2,
        GAP    = 3'd3,
        STREAM = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                    state, next_state;
    logic [CW-1:0]             k_q, wr_cnt, rd_cnt;
    logic [$clog2(NUM_PE)-1:0] p_q;
    logic [DATA_WIDTH-1:0]     mem [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0]     w_data_q;
    logic                      err_q;
    logic                      start_ok, start_go, accept, reject;

    assign start_ok = (kernel_size != 8'd0) && (kernel_size <= 8'(BUFFER_DEPTH))
                      && bus.un_configed[pe_sel];
    assign start_go = (state == IDLE) && start && start_ok;
    assign accept   = (state == FILL) && bus.s_valid;

`ifdef WLOAD_REPLAY_EN
    logic loaded_q, replay_ok, replay_go;
    // Replay needs a completed load whose FIFO contents are still intact.
    assign replay_ok = loaded_q && bus.un_configed[pe_sel];
    assign replay_go = (state == IDLE) && !start && replay && replay_ok;
    assign reject    = (state == IDLE) && ((start && !start_ok) || (!start && replay && !replay_ok));
`else
    assign reject    = (state == IDLE) && start && !start_ok;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_go) next_state = FILL;
`ifdef WLOAD_REPLAY_EN
                else if (replay_go) next_state = FLUSH;
`endif
            end
            FILL:    if (accept && (wr_cnt == k_q - 1'b1)) next_state = FLUSH;
            FLUSH:   next_state = GAP;
            GAP:     next_state = STREAM;
            STREAM:  if (rd_cnt == k_q) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready      = (state == FILL);
        bus.flush_kernel = '0;
        if (state == FLUSH) bus.flush_kernel = {{(NUM_PE-1){1'b0}}, 1'b1} << p_q;
        bus.w_data = w_data_q;
        busy       = (state != IDLE);
        done       = (state == DONE);
        err        = err_q;
        state_dbg  = state;
    end

    // rd_cnt counts words already loaded into w_data_q, so STREAM lasts exactly k_q cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q      <= '0;
            p_q      <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            w_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= reject;
            if (start_go) begin
                k_q    <= kernel_size[CW-1:0];
                p_q    <= pe_sel;
                wr_cnt <= '0;
            end
`ifdef WLOAD_REPLAY_EN
            if (replay_go) p_q <= pe_sel;
`endif
            if (accept) wr_cnt <= wr_cnt + 1'b1;
            if (state == FLUSH) rd_cnt <= '0;
            if (next_state == STREAM) begin
                w_data_q <= mem[rd_cnt[AW-1:0]];
                rd_cnt   <= rd_cnt + 1'b1;
            end else begin
                w_data_q <= '0;
            end
        end
    end

`ifdef WLOAD_REPLAY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)              loaded_q <= 1'b0;
        else if (start_go)      loaded_q <= 1'b0;
        else if (state == DONE) loaded_q <= 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) mem[wr_cnt[AW-1:0]] <= bus.s_data;
    end
endmodule

// File: tb/tb_weight_loader.sv
// Directed and randomized bench for weight_loader; replay steps run when WLOAD_REPLAY_EN is defined.
module tb_weight_loader;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  kernel_size;
    logic [1:0]  pe_sel;
    logic        busy, done, err;
    logic [2:0]  state_dbg;
`ifdef WLOAD_REPLAY_EN
    logic        replay;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_q[$];

    weight_loader_if #(.DATA_WIDTH(16), .NUM_PE(4)) bus ();

    weight_loader #(.DATA_WIDTH(16), .BUFFER_DEPTH(16), .NUM_PE(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .kernel_size (kernel_size),
        .pe_sel      (pe_sel),
`ifdef WLOAD_REPLAY_EN
        .replay      (replay),
`endif
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_flush"}, 32'(bus.flush_kernel), 32'd0);
        check({tag, "_wdata"}, 32'(bus.w_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Rejected request: err pulses one cycle after the request, loader never leaves IDLE.
    task automatic bad_request(input string tag, input int k, input int p, input logic [3:0] uc,
                               input bit use_replay);
        bus.un_configed = uc;
        pe_sel          = 2'(p);
        if (use_replay) begin
`ifdef WLOAD_REPLAY_EN
            replay = 1'b1;
`endif
        end else begin
            start       = 1'b1;
            kernel_size = 8'(k);
        end
        @(negedge clk);
        start = 1'b0;
`ifdef WLOAD_REPLAY_EN
        replay = 1'b0;
`endif
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_err_end"}, 32'(err), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        bus.un_configed = 4'hF;
    endtask

    // One complete load of exp_q to PE p. mode: 0 valid always, 1 valid toggling, 2 random.
    task automatic do_load(input int k, input int p, input int mode, input bit replay_run,
                           input int rst_at, input bit poke_start);
        int  acc;
        int  cyc;
        bit  sv;
        check("idle_busy", 32'(busy), 32'd0);
        pe_sel = 2'(p);
        if (replay_run) begin
`ifdef WLOAD_REPLAY_EN
            replay = 1'b1;
`endif
        end else begin
            start       = 1'b1;
            kernel_size = 8'(k);
        end
        @(negedge clk);
        start = 1'b0;
`ifdef WLOAD_REPLAY_EN
        replay = 1'b0;
`endif
        if (!replay_run) begin
            acc = 0;
            cyc = 0;
            while (acc < k && cyc < 200) begin
                check("fill_ready", 32'(bus.s_ready), 32'd1);
                check("fill_busy", 32'(busy), 32'd1);
                check("fill_wdata", 32'(bus.w_data), 32'd0);
                case (mode)
                    0:       sv = 1'b1;
                    1:       sv = (cyc % 2 == 0);
                    default: sv = 1'($urandom_range(0, 1));
                endcase
                bus.s_valid = sv;
                bus.s_data  = sv ? exp_q[acc] : 16'($urandom);
                if (sv && bus.s_ready) acc++;
                @(negedge clk);
                cyc++;
            end
            check("fill_count", 32'(acc), 32'(k));
            if (mode == 0) check("fill_cycles", 32'(cyc), 32'(k));
            if (mode == 1) check("fill_cycles", 32'(cyc), 32'(2 * k - 1));
        end
        // Excess upstream words stay on offer and must not be taken.
        bus.s_valid = 1'b1;
        bus.s_data  = 16'($urandom);
        check("flush_strobe", 32'(bus.flush_kernel), 32'(1 << p));
        check("flush_wdata", 32'(bus.w_data), 32'd0);
        check("flush_ready", 32'(bus.s_ready), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("gap_flush", 32'(bus.flush_kernel), 32'd0);
        check("gap_wdata", 32'(bus.w_data), 32'd0);
        check("gap_ready", 32'(bus.s_ready), 32'd0);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("stream_wdata", 32'(bus.w_data), 32'(exp_q[i]));
            check("stream_flush", 32'(bus.flush_kernel), 32'd0);
            check("stream_ready", 32'(bus.s_ready), 32'd0);
            check("stream_done", 32'(done), 32'd0);
            if (i == rst_at) begin
                rstn = 1'b0;
                #1;
                check_quiet("midrst");
                @(negedge clk);
                rstn        = 1'b1;
                bus.s_valid = 1'b0;
                start       = 1'b0;
                return;
            end
            if (poke_start) begin
                start       = 1'($urandom_range(0, 1));
                kernel_size = 8'($urandom_range(0, 20));
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_wdata", 32'(bus.w_data), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check_quiet("post_done");
        if (!replay_run) last_q = exp_q;
    endtask

    task automatic fill_random(input int k);
        exp_q.delete();
        for (int i = 0; i < k; i++) exp_q.push_back(16'($urandom));
    endtask

    initial begin
        rstn            = 1'b0;
        start           = 1'b0;
        kernel_size     = 8'd0;
        pe_sel          = 2'd0;
        bus.s_data      = 16'd0;
        bus.s_valid     = 1'b0;
        bus.un_configed = 4'hF;
`ifdef WLOAD_REPLAY_EN
        replay          = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_state", 32'(state_dbg), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_quiet("after_reset");

`ifdef WLOAD_REPLAY_EN
        bad_request("replay_no_load", 0, 0, 4'hF, 1'b1);
`endif

        exp_q.delete();
        for (int i = 1; i <= 9; i++) exp_q.push_back(16'(i));
        do_load(9, 2, 0, 1'b0, -1, 1'b0);

        exp_q = '{16'hA, 16'hB, 16'hC, 16'hD};
        do_load(4, 1, 1, 1'b0, -1, 1'b0);

        bad_request("ksize_zero", 0, 0, 4'hF, 1'b0);
        bad_request("ksize_17", 17, 0, 4'hF, 1'b0);
        bad_request("pe_configed", 2, 1, 4'b1101, 1'b0);

        fill_random(16);
        do_load(16, 0, 0, 1'b0, -1, 1'b1);

        fill_random(8);
        do_load(8, $urandom_range(0, 3), 0, 1'b0, 4, 1'b0);
        check_quiet("after_midrst");
        fill_random(2);
        do_load(2, 3, 0, 1'b0, -1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            int k;
            k = $urandom_range(1, 16);
            fill_random(k);
            do_load(k, $urandom_range(0, 3), 2, 1'b0, -1, 1'b0);
        end

`ifdef WLOAD_REPLAY_EN
        exp_q = '{16'd7, 16'd8, 16'd9};
        do_load(3, 0, 0, 1'b0, -1, 1'b0);
        bad_request("replay_configed", 0, 3, 4'b0111, 1'b1);
        exp_q = last_q;
        do_load(3, 3, 0, 1'b1, -1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
